// File: rtl/ansi_pkg.sv
// rtl/ansi_pkg.sv - byte codes, cell layout, parser states and SGR helper for the ANSI VRAM decoder
package ansi_pkg;

    localparam logic [7:0] CH_ESC    = 8'h1B;
    localparam logic [7:0] CH_LBRACK = 8'h5B;
    localparam logic [7:0] CH_QMARK  = 8'h3F;
    localparam logic [7:0] CH_SEMI   = 8'h3B;
    localparam logic [7:0] CH_H      = 8'h48;
    localparam logic [7:0] CH_M      = 8'h6D;
    localparam logic [7:0] CH_J      = 8'h4A;
    localparam logic [7:0] CH_L      = 8'h6C;
    localparam logic [7:0] CH_HS     = 8'h68;

    localparam int CELL_BOLD   = 15;
    localparam int CELL_UL     = 14;
    localparam int CELL_FG_LSB = 11;
    localparam int CELL_BG_LSB = 8;

    localparam logic [15:0] ATTR_DEFAULT = 16'h3800;

    localparam int COL_W = 6;
    localparam int P_W   = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ESC,
        S_CSI,
        S_CLEAR
    } state_t;

    // Attribute byte is the upper half of a cell: {bold, ul, fg[2:0], bg[2:0]}.
    function automatic logic [7:0] sgr_apply(input logic [7:0] attr, input logic [P_W-1:0] p);
        logic [7:0] a;
        a = attr;
        if (p == 7'd0) begin
            a = ATTR_DEFAULT[15:8];
        end else if (p == 7'd1) begin
            a[CELL_BOLD-8] = 1'b1;
        end else if (p == 7'd4) begin
            a[CELL_UL-8] = 1'b1;
        end else if (p >= 7'd30 && p <= 7'd37) begin
            a[CELL_FG_LSB-8 +: 3] = 3'(p - 7'd30);
        end else if (p >= 7'd40 && p <= 7'd47) begin
            a[CELL_BG_LSB-8 +: 3] = 3'(p - 7'd40);
        end
        return a;
    endfunction

endpackage

// File: rtl/ansi_vram_decoder_if.sv
// rtl/ansi_vram_decoder_if.sv - byte input and VRAM/status output bundle of the decoder
interface ansi_vram_decoder_if #(
    parameter int ADDR_W = 11
);
    logic [7:0]        RX_DATA;
    logic              RX_VALID;
    logic              VRAM_ENABLE;
    logic              VRAM_WRITE;
    logic [ADDR_W-1:0] VRAM_ADDR;
    logic [15:0]       VRAM_DATA_W;
    logic              CURSOR_VISIBLE;
    logic              BUSY;
    logic              OVERRUN;

    modport master (
        output RX_DATA, RX_VALID,
        input  VRAM_ENABLE, VRAM_WRITE, VRAM_ADDR, VRAM_DATA_W,
        input  CURSOR_VISIBLE, BUSY, OVERRUN
    );

    modport slave (
        input  RX_DATA, RX_VALID,
        output VRAM_ENABLE, VRAM_WRITE, VRAM_ADDR, VRAM_DATA_W,
        output CURSOR_VISIBLE, BUSY, OVERRUN
    );
endinterface

// File: rtl/ansi_param_acc.sv
// rtl/ansi_param_acc.sv - two-slot saturating decimal CSI parameter accumulator
module ansi_param_acc
    import ansi_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           digit_en_i,
    input  logic [3:0]     digit_i,
    input  logic           step_i,
    output logic [P_W-1:0] p0_o,
    output logic [P_W-1:0] p1_o,
    output logic           idx_o
);

    logic [P_W-1:0] p0_q, p0_d, p1_q, p1_d;
    logic           idx_q, idx_d;
    logic [P_W-1:0] cur;
    logic [9:0]     prod;
    logic [P_W-1:0] sat;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p0_q  <= '0;
            p1_q  <= '0;
            idx_q <= 1'b0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            idx_q <= idx_d;
        end
    end

    // Once idx saturates at 1, every further ';' recycles p1 for the next parameter.
    always_comb begin
        p0_d  = p0_q;
        p1_d  = p1_q;
        idx_d = idx_q;
        cur   = idx_q ? p1_q : p0_q;
        prod  = 10'(cur) * 10'd10 + 10'(digit_i);
        sat   = (prod > 10'd99) ? 7'd99 : prod[P_W-1:0];
        if (clr_i) begin
            p0_d  = '0;
            p1_d  = '0;
            idx_d = 1'b0;
        end else if (digit_en_i) begin
            if (idx_q) p1_d = sat;
            else       p0_d = sat;
        end else if (step_i) begin
            p1_d  = '0;
            idx_d = 1'b1;
        end
    end

    assign p0_o  = p0_q;
    assign p1_o  = p1_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/ansi_vram_decoder.sv
// rtl/ansi_vram_decoder.sv - rebuilds the VRAM cell image from an ANSI/VT100 byte stream
module ansi_vram_decoder
    import ansi_pkg::*;
#(
    parameter int ROWS   = 20,
    parameter int COLS   = 64,
    parameter int ADDR_W = 11
) (
    input logic               CLK,
    input logic               RESET,
    ansi_vram_decoder_if.slave bus
);

    localparam logic [P_W-1:0]    ROW_MAX  = P_W'(ROWS);
    localparam logic [P_W-1:0]    COL_LAST = P_W'(COLS);
    localparam logic [P_W-1:0]    COL_SAT  = P_W'(COLS + 1);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ROWS * COLS - 1);

    state_t            state_q, state_d;
    logic [P_W-1:0]    row_q, row_d, col_q, col_d;
    logic [7:0]        attr_q, attr_d, sh_q, sh_d;
    logic              priv_q, priv_d, first_q, first_d;
    logic              vis_q, vis_d, busy_q, busy_d, ovr_q, ovr_d;
    logic              ven_q, ven_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d, clr_q, clr_d;
    logic [15:0]       vdata_q, vdata_d;

    logic              acc_clr, acc_digit, acc_step;
    logic [P_W-1:0]    p0, p1, cur_p;
    logic              idx;
    logic [7:0]        rx;
    logic              is_digit;
    logic [P_W-1:0]    row_m1, col_m1;
    logic [ADDR_W-1:0] cell_addr;
    logic              in_range;

    ansi_param_acc u_acc (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .clr_i      (acc_clr),
        .digit_en_i (acc_digit),
        .digit_i    (rx[3:0]),
        .step_i     (acc_step),
        .p0_o       (p0),
        .p1_o       (p1),
        .idx_o      (idx)
    );

    assign rx        = bus.RX_DATA;
    assign is_digit  = (rx >= 8'h30) && (rx <= 8'h39);
    assign cur_p     = idx ? p1 : p0;
    assign row_m1    = row_q - 7'd1;
    assign col_m1    = col_q - 7'd1;
    assign cell_addr = (ADDR_W'(row_m1) << COL_W) | ADDR_W'(col_m1[COL_W-1:0]);
    assign in_range  = (row_q != '0) && (row_q <= ROW_MAX) && (col_q != '0) && (col_q <= COL_LAST);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            row_q   <= 7'd1;
            col_q   <= 7'd1;
            attr_q  <= ATTR_DEFAULT[15:8];
            sh_q    <= ATTR_DEFAULT[15:8];
            priv_q  <= 1'b0;
            first_q <= 1'b0;
            vis_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ven_q   <= 1'b0;
            vaddr_q <= '0;
            vdata_q <= '0;
            clr_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            attr_q  <= attr_d;
            sh_q    <= sh_d;
            priv_q  <= priv_d;
            first_q <= first_d;
            vis_q   <= vis_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
            ven_q   <= ven_d;
            vaddr_q <= vaddr_d;
            vdata_q <= vdata_d;
            clr_q   <= clr_d;
        end
    end

    // SGR updates build up in a shadow copy and only commit on 'm', so the
    // ';'-separated params of an H sequence never disturb the live attributes.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        attr_d    = attr_q;
        sh_d      = sh_q;
        priv_d    = priv_q;
        first_d   = first_q;
        vis_d     = vis_q;
        busy_d    = (state_q == S_CLEAR);
        ovr_d     = ovr_q;
        ven_d     = 1'b0;
        vaddr_d   = vaddr_q;
        vdata_d   = vdata_q;
        clr_d     = clr_q;
        acc_clr   = 1'b0;
        acc_digit = 1'b0;
        acc_step  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.RX_VALID) begin
                    if (rx == CH_ESC) begin
                        state_d = S_ESC;
                    end else if (rx >= 8'h20 && rx <= 8'h7E) begin
                        if (in_range) begin
                            ven_d   = 1'b1;
                            vaddr_d = cell_addr;
                            vdata_d = {attr_q, rx};
                        end
                        if (col_q < COL_SAT) col_d = col_q + 7'd1;
                    end
                end
            end
            S_ESC: begin
                if (bus.RX_VALID) begin
                    if (rx == CH_LBRACK) begin
                        state_d = S_CSI;
                        acc_clr = 1'b1;
                        priv_d  = 1'b0;
                        first_d = 1'b1;
                        sh_d    = attr_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_CSI: begin
                if (bus.RX_VALID) begin
                    first_d = 1'b0;
                    if (rx == CH_ESC) begin
                        state_d = S_ESC;
                    end else if (rx == CH_QMARK) begin
                        if (first_q) priv_d = 1'b1;
                    end else if (is_digit) begin
                        acc_digit = 1'b1;
                    end else if (rx == CH_SEMI) begin
                        sh_d     = sgr_apply(sh_q, cur_p);
                        acc_step = 1'b1;
                    end else if (rx >= 8'h40 && rx <= 8'h7E) begin
                        state_d = S_IDLE;
                        case (rx)
                            CH_H: begin
                                row_d = (p0 == '0) ? 7'd1 : p0;
                                col_d = (p1 == '0) ? 7'd1 : p1;
                            end
                            CH_M: attr_d = sgr_apply(sh_q, cur_p);
                            CH_J: begin
                                if (p0 == 7'd2) begin
                                    state_d = S_CLEAR;
                                    clr_d   = '0;
                                end
                            end
                            CH_L:  if (priv_q && p0 == 7'd25) vis_d = 1'b0;
                            CH_HS: if (priv_q && p0 == 7'd25) vis_d = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                ven_d   = 1'b1;
                vaddr_d = clr_q;
                vdata_d = '0;
                if (clr_q == CLR_LAST) state_d = S_IDLE;
                else                   clr_d   = clr_q + 1'b1;
                if (bus.RX_VALID) ovr_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.VRAM_ENABLE    = ven_q;
    assign bus.VRAM_WRITE     = ven_q;
    assign bus.VRAM_ADDR      = vaddr_q;
    assign bus.VRAM_DATA_W    = vdata_q;
    assign bus.CURSOR_VISIBLE = vis_q;
    assign bus.BUSY           = busy_q;
    assign bus.OVERRUN        = ovr_q;

endmodule

// File: tb/tb_ansi_vram_decoder.sv
// tb/tb_ansi_vram_decoder.sv - directed self-checking bench for ansi_vram_decoder
module tb_ansi_vram_decoder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   wr_cnt      = 0;
    int   w0;
    int   busy_cnt;
    int   clr_bad;

    ansi_vram_decoder_if #(.ADDR_W(11)) bus ();

    ansi_vram_decoder #(.ROWS(20), .COLS(64), .ADDR_W(11)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.VRAM_ENABLE && bus.VRAM_WRITE) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.RX_DATA  = b;
        bus.RX_VALID = 1'b1;
        @(negedge clk);
        bus.RX_VALID = 1'b0;
    endtask

    task automatic send_csi(input string s);
        send_byte(8'h1B);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    initial begin
        bus.RX_DATA  = 8'h00;
        bus.RX_VALID = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_en",   32'(bus.VRAM_ENABLE), 32'h0);
        chk("rst_we",   32'(bus.VRAM_WRITE), 32'h0);
        chk("rst_addr", 32'(bus.VRAM_ADDR), 32'h0);
        chk("rst_data", 32'(bus.VRAM_DATA_W), 32'h0);
        chk("rst_vis",  32'(bus.CURSOR_VISIBLE), 32'h1);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_ovr",  32'(bus.OVERRUN), 32'h0);
        rst = 1'b0;

        send_byte(8'h42);
        chk("B_en",   32'(bus.VRAM_ENABLE), 32'h1);
        chk("B_we",   32'(bus.VRAM_WRITE), 32'h1);
        chk("B_addr", 32'(bus.VRAM_ADDR), 32'h000);
        chk("B_data", 32'(bus.VRAM_DATA_W), 32'h3842);
        chk("B_vis",  32'(bus.CURSOR_VISIBLE), 32'h1);
        @(negedge clk);
        chk("B_pulse", 32'(bus.VRAM_ENABLE), 32'h0);

        w0 = wr_cnt;
        send_csi("[3;5H");
        send_csi("[0;1;31;44m");
        send_byte(8'h41);
        chk("A_addr", 32'(bus.VRAM_ADDR), 32'h084);
        chk("A_data", 32'(bus.VRAM_DATA_W), 32'h8C41);
        repeat (2) @(negedge clk);
        chk("A_wrcnt", 32'(wr_cnt - w0), 32'd1);

        w0 = wr_cnt;
        send_csi("[1;64H");
        send_byte(8'h58);
        chk("X_addr", 32'(bus.VRAM_ADDR), 32'h03F);
        chk("X_data", 32'(bus.VRAM_DATA_W), 32'h8C58);
        send_byte(8'h59);
        chk("Y_noen", 32'(bus.VRAM_ENABLE), 32'h0);
        repeat (2) @(negedge clk);
        chk("XY_wrcnt", 32'(wr_cnt - w0), 32'd1);

        w0 = wr_cnt;
        send_csi("[2J");
        busy_cnt = 0;
        clr_bad  = 0;
        for (int i = 0; i < 1400; i++) begin
            @(negedge clk);
            if (bus.BUSY) begin
                if (!(bus.VRAM_ENABLE && bus.VRAM_WRITE && bus.VRAM_DATA_W == 16'h0 &&
                      bus.VRAM_ADDR == 11'(busy_cnt))) clr_bad++;
                busy_cnt++;
            end
            bus.RX_DATA  = 8'h5A;
            bus.RX_VALID = (i == 200);
        end
        chk("clr_busy_cycles", 32'(busy_cnt), 32'd1280);
        chk("clr_bad_writes",  32'(clr_bad), 32'd0);
        chk("clr_wrcnt",       32'(wr_cnt - w0), 32'd1280);
        chk("clr_overrun",     32'(bus.OVERRUN), 32'h1);
        chk("clr_busy_end",    32'(bus.BUSY), 32'h0);

        send_csi("[20;1H");
        send_csi("[?25l");
        chk("hide_vis", 32'(bus.CURSOR_VISIBLE), 32'h0);
        send_csi("[?25h");
        chk("show_vis", 32'(bus.CURSOR_VISIBLE), 32'h1);
        w0 = wr_cnt;
        send_csi("[5X");
        send_byte(8'h43);
        chk("C_addr", 32'(bus.VRAM_ADDR), 32'h4C0);
        chk("C_data", 32'(bus.VRAM_DATA_W), 32'h8C43);
        repeat (2) @(negedge clk);
        chk("C_wrcnt", 32'(wr_cnt - w0), 32'd1);

        send_csi("[1;");
        send_csi("[4m");
        send_byte(8'h44);
        chk("D_addr", 32'(bus.VRAM_ADDR), 32'h4C1);
        chk("D_data", 32'(bus.VRAM_DATA_W), 32'hCC44);
        chk("D_ul",   32'(bus.VRAM_DATA_W[14]), 32'h1);

        send_csi("[?25l");
        send_byte(8'h1B);
        send_byte(8'h5B);
        send_byte(8'h33);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_vis",  32'(bus.CURSOR_VISIBLE), 32'h1);
        chk("arst_ovr",  32'(bus.OVERRUN), 32'h0);
        chk("arst_addr", 32'(bus.VRAM_ADDR), 32'h0);
        chk("arst_data", 32'(bus.VRAM_DATA_W), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h45);
        chk("E_en",   32'(bus.VRAM_ENABLE), 32'h1);
        chk("E_addr", 32'(bus.VRAM_ADDR), 32'h000);
        chk("E_data", 32'(bus.VRAM_DATA_W), 32'h3845);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
